// File: rtl/key_debounce_repeat_if.sv
// Key conditioner bus: raw active-low pins in, debounced and repeat levels out.
interface key_debounce_repeat_if;
    logic [1:0] KEY;        // raw push-buttons, active-low
    logic [1:0] KEYSTABLE;  // debounced level, 1 = pressed
    logic [1:0] KEYOUT;     // debounced level with auto-repeat, 1 = pressed

    modport master (output KEY, input KEYSTABLE, input KEYOUT);
    modport slave  (input KEY, output KEYSTABLE, output KEYOUT);
endinterface

// File: rtl/key_debounce_repeat.sv
// Two-key conditioner for the clock PIO: 2-FF sync, tick-based debounce,
// inversion to active-high, and a per-key auto-repeat pattern on KEYOUT.
module key_debounce_repeat #(
    parameter int TICK_CYCLES     = 50000,
    parameter int DEB_TICKS       = 20,
    parameter int REP_DELAY_TICKS = 500,
    parameter int REP_HALF_TICKS  = 50
) (
    input logic                  clk,
    input logic                  reset,
    key_debounce_repeat_if.slave kif
);

    localparam int TW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW       = $clog2(DEB_TICKS + 1);
    localparam int TMAX     = (REP_DELAY_TICKS > REP_HALF_TICKS) ? REP_DELAY_TICKS : REP_HALF_TICKS;
    localparam int RW       = $clog2(TMAX + 1);
    localparam int DLY_LAST = (REP_DELAY_TICKS > 0) ? REP_DELAY_TICKS - 1 : 0;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] DELAY_END = RW'(DLY_LAST);
    localparam logic [RW-1:0] HALF_END  = RW'(REP_HALF_TICKS - 1);
    localparam bit            REP_EN    = (REP_DELAY_TICKS != 0);

    typedef enum logic [1:0] {IDLE, HOLD, R_OFF, R_ON} rep_state_e;

    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    sample;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [1:0]    keystable_v, keyout_v;

    // Synchroniser next-state: plain two-stage shift of the raw pins.
    always_comb begin
        sync1_d = kif.KEY;
        sync2_d = sync1_q;
    end

    // Synchroniser flops; released level (1) out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = ~sync2_q;

    // Free-running prescaler; tick marks the last count of each period.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic [DW-1:0] deb_cnt_q, deb_cnt_d;
        logic          stable_q, stable_d;
        rep_state_e    state_q;
        logic [RW-1:0] timer_q;
        logic          keyout_q;

        // Debounce: count disagreeing ticks, any agreeing tick starts over.
        always_comb begin
            deb_cnt_d = deb_cnt_q;
            stable_d  = stable_q;
            if (tick) begin
                if (sample[i] == stable_q) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    stable_d  = sample[i];
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        end

        // Debounce registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                deb_cnt_q <= '0;
                stable_q  <= 1'b0;
            end else begin
                deb_cnt_q <= deb_cnt_d;
                stable_q  <= stable_d;
            end
        end

        // Repeat FSM with registered KEYOUT; release beats any timer expiry.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= IDLE;
                timer_q  <= '0;
                keyout_q <= 1'b0;
            end else if (!stable_q) begin
                state_q  <= IDLE;
                timer_q  <= '0;
                keyout_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= HOLD;
                        timer_q  <= '0;
                        keyout_q <= 1'b1;
                    end
                    HOLD: begin
                        // With repeat disabled the timer never moves, so it cannot wrap.
                        if (tick && REP_EN) begin
                            if (timer_q == DELAY_END) begin
                                state_q  <= R_OFF;
                                timer_q  <= '0;
                                keyout_q <= 1'b0;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    R_OFF: begin
                        if (tick) begin
                            if (timer_q == HALF_END) begin
                                state_q  <= R_ON;
                                timer_q  <= '0;
                                keyout_q <= 1'b1;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    R_ON: begin
                        if (tick) begin
                            if (timer_q == HALF_END) begin
                                state_q  <= R_OFF;
                                timer_q  <= '0;
                                keyout_q <= 1'b0;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        timer_q  <= '0;
                        keyout_q <= 1'b0;
                    end
                endcase
            end
        end

        assign keystable_v[i] = stable_q;
        assign keyout_v[i]    = keyout_q;
    end

    assign kif.KEYSTABLE = keystable_v;
    assign kif.KEYOUT    = keyout_v;

endmodule
